bcd_to_binary_converter: RTL

Sequential inverse of the team's binary-to-BCD converter, using the reverse double-dabble algorithm (shift right, then subtract 3). It converts a packed BCD number, such as an operator setpoint entered on the keypad or seven-segment UI, into a binary value for the PWM/timer datapath. Each conversion uses a start/busy/done handshake, takes a fixed latency, and flags invalid digits and overflow.

---
 rtl/bcd_to_binary_converter_pkg.sv | 22 ++
 rtl/bcd_digit_corrector.sv | 18 +
 rtl/bcd_to_binary_converter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_converter_pkg.sv
// Shared definitions for the BCD <-> binary converters.
//   state_e : conversion FSM states (idle, shifting, result presentation)
//   clog2   : constant function used to size the shift-step counter
package bcd_to_binary_converter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StFinish = 2'd2
    } state_e;

    // Smallest r with 2**r >= value; 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < {32'd0, value}) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_corrector.sv
// Reverse double-dabble correction for one BCD digit.
//   nibble_i : digit after the right shift
//   nibble_o : nibble_i - 3 when nibble_i >= 8, otherwise nibble_i unchanged
module bcd_digit_corrector (
    input  logic [3:0] nibble_i,
    output logic [3:0] nibble_o
);

    // A digit >= 8 after the shift means a 1 moved down from the next decade (worth 5
    // instead of 8), so take 3 back off. The subtract stays within 4 bits.
    always_comb begin
        nibble_o = nibble_i;
        if (nibble_i >= 4'd8) begin
            nibble_o = nibble_i - 4'd3;
        end
    end

endmodule

// File: rtl/bcd_to_binary_converter.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
//   Clk           : clock, rising edge
//   reset         : asynchronous active-high reset; aborts a conversion in flight
//   start         : request a conversion, accepted only when idle
//   BCDNumber     : packed BCD operand, digit 0 in bits [3:0], sampled on acceptance
//   busy          : conversion in progress
//   done          : one-cycle pulse, results valid
//   BinaryNumber  : result (input mod 2**BitWidth), held until the next done
//   invalid_digit : some input nibble was > 9, held until the next done
//   overflow      : input exceeded 2**BitWidth-1, held until the next done
module bcd_to_binary_converter
    import bcd_to_binary_converter_pkg::*;
#(
    parameter int unsigned BitWidth  = 17,
    parameter int unsigned BCDDigits = 6
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BCDDigits*4-1:0] BCDNumber,
    output logic                   busy,
    output logic                   done,
    output logic [BitWidth-1:0]    BinaryNumber,
    output logic                   invalid_digit,
    output logic                   overflow
);

    localparam int unsigned BcdW = BCDDigits * 4;
    localparam int unsigned CntW = clog2(BitWidth + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(BitWidth);

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [BcdW-1:0]     bcd_q;
    logic [BitWidth-1:0] bin_q;

    logic [BcdW-1:0]     bcd_shift;
    logic [BcdW-1:0]     bcd_corr;
    logic [BitWidth-1:0] bin_shift;
    logic                input_invalid;

    // Working register {bcd_q, bin_q} shifted right by one, zero into the MSB.
    always_comb begin
        bcd_shift = {1'b0, bcd_q[BcdW-1:1]};
        bin_shift = {bcd_q[0], bin_q[BitWidth-1:1]};
    end

    for (genvar g = 0; g < BCDDigits; g++) begin : g_corr
        bcd_digit_corrector u_corr (
            .nibble_i (bcd_shift[g*4 +: 4]),
            .nibble_o (bcd_corr[g*4 +: 4])
        );
    end

    always_comb begin
        input_invalid = 1'b0;
        for (int i = 0; i < BCDDigits; i++) begin
            if (BCDNumber[i*4 +: 4] > 4'd9) begin
                input_invalid = 1'b1;
            end
        end
    end

    // Results and done are registered on the edge that enters StFinish, so they appear
    // together for the single cycle spent there.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bcd_q         <= '0;
            bin_q         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            BinaryNumber  <= '0;
            invalid_digit <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        bcd_q <= BCDNumber;
                        bin_q <= '0;
                        cnt_q <= CntW'(1);
                        if (input_invalid) begin
                            state_q       <= StFinish;
                            done          <= 1'b1;
                            BinaryNumber  <= '0;
                            invalid_digit <= 1'b1;
                            overflow      <= 1'b0;
                        end else begin
                            state_q <= StShift;
                            busy    <= 1'b1;
                        end
                    end
                end
                StShift: begin
                    bin_q <= bin_shift;
                    if (cnt_q == LastCnt) begin
                        // Final step is uncorrected; any residue left means the value
                        // did not fit in BitWidth bits.
                        bcd_q         <= bcd_shift;
                        state_q       <= StFinish;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        BinaryNumber  <= bin_shift;
                        overflow      <= (bcd_shift != '0);
                        invalid_digit <= 1'b0;
                    end else begin
                        bcd_q <= bcd_corr;
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StFinish: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
